// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate controller and its display block.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTERING = 2'd1,
    EXITING  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_CLK_FREQUENCY = 40_000_000;
  localparam int unsigned DEFAULT_CAPACITY      = 8;
  localparam int unsigned DEFAULT_GATE_OPEN_SEC = 3;

  // Counter width for a window of `cycles` cycles; never below one bit.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/parking_gate_controller_gate_timer.sv
// Gate window timer: start loads zero, then counts up while run_i is high; done_o marks the
// last cycle of a GATE_CYCLES-long window.
module gate_timer
  import parking_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic run_i,
  output logic done_o
);

  localparam int unsigned TMR_W = timer_width(GATE_CYCLES);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(GATE_CYCLES - 1);

  logic [TMR_W-1:0] count_q, count_d;

  assign done_o = run_i && (count_q == LAST);

  // Count rests at zero outside a window so every window starts from a clean load.
  always_comb begin
    count_d = count_q + 1'b1;
    if (start_i || !run_i || done_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Parking lot controller: occupancy tracking, timed entry/exit gate windows and reject pulses.
// Build option PARK_PENDING_EN: queue one request per direction while a gate is busy.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter  int unsigned CLK_FREQUENCY = DEFAULT_CLK_FREQUENCY,
  parameter  int unsigned CAPACITY      = DEFAULT_CAPACITY,
  parameter  int unsigned GATE_OPEN_SEC = DEFAULT_GATE_OPEN_SEC,
  localparam int unsigned GATE_CYCLES   = CLK_FREQUENCY * GATE_OPEN_SEC,
  localparam int unsigned OCC_W         = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic [OCC_W-1:0] occupancy,
  output logic [OCC_W-1:0] free_slots,
  output logic             full,
  output logic             empty,
  output logic             gate_in_open,
  output logic             gate_out_open,
  output logic             reject,
  output state_t           state_o
);

`ifdef PARK_PENDING_EN
  localparam logic PEND_EN = 1'b1;
`else
  localparam logic PEND_EN = 1'b0;
`endif

  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

  state_t           state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             gin_q, gin_d;
  logic             gout_q, gout_d;
  logic             rej_q, rej_d;
  logic             pend_in_q, pend_in_d;
  logic             pend_out_q, pend_out_d;
  logic             tmr_start, tmr_done;
  logic             want_entry, want_exit;

  gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_gate_timer (
    .clk    (clk),
    .rst_n  (reset),
    .start_i(tmr_start),
    .run_i  (state_q != IDLE),
    .done_o (tmr_done)
  );

  assign occupancy     = occ_q;
  assign free_slots    = CAP - occ_q;
  assign full          = (occ_q == CAP);
  assign empty         = (occ_q == '0);
  assign gate_in_open  = gin_q;
  assign gate_out_open = gout_q;
  assign reject        = rej_q;
  assign state_o       = state_q;

  // Pending flags are always zero without PARK_PENDING_EN, so these reduce to the raw pulses.
  assign want_entry = entry_req || pend_in_q;
  assign want_exit  = exit_req || pend_out_q;

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    gin_d      = gin_q;
    gout_d     = gout_q;
    rej_d      = 1'b0;
    pend_in_d  = pend_in_q;
    pend_out_d = pend_out_q;
    tmr_start  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (want_exit && !empty) begin
          state_d    = EXITING;
          occ_d      = occ_q - OCC_W'(1);
          gout_d     = 1'b1;
          tmr_start  = 1'b1;
          pend_out_d = 1'b0;
          // A simultaneous entry loses to the exit and is treated as a busy request.
          pend_in_d  = PEND_EN & want_entry;
        end else begin
          if (want_exit) begin
            rej_d      = 1'b1;
            pend_out_d = 1'b0;
          end
          if (want_entry && !full) begin
            state_d   = ENTERING;
            occ_d     = occ_q + OCC_W'(1);
            gin_d     = 1'b1;
            tmr_start = 1'b1;
            pend_in_d = 1'b0;
          end else if (want_entry) begin
            rej_d     = 1'b1;
            pend_in_d = 1'b0;
          end
        end
      end
      ENTERING, EXITING: begin
        pend_in_d  = pend_in_q | (PEND_EN & entry_req);
        pend_out_d = pend_out_q | (PEND_EN & exit_req);
        if (tmr_done) begin
          state_d = IDLE;
          gin_d   = 1'b0;
          gout_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gin_d   = 1'b0;
        gout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      occ_q      <= '0;
      gin_q      <= 1'b0;
      gout_q     <= 1'b0;
      rej_q      <= 1'b0;
      pend_in_q  <= 1'b0;
      pend_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      gin_q      <= gin_d;
      gout_q     <= gout_d;
      rej_q      <= rej_d;
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
    end
  end

endmodule
